// File: rtl/top_pipe_cpu.sv
// 5-stage in-order 16-bit CPU (IF/ID/EX/MEM/WB) with a boot-loaded instruction
// memory, a write-through register file, full forwarding and a load-use stall.
// Every data-memory store is mirrored onto the peripheral write port.
// rst_n keeps its historical name but is an active-high synchronous reset.
module top_pipe_cpu #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_up,
  input  logic [7:0]        boot_addr,
  input  logic [31:0]       boot_datai,
  input  logic              boot_web,
  output logic              peri_web,
  output logic [DATA_W-1:0] peri_addr,
  output logic [DATA_W-1:0] peri_datao
);
  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22,
                         F_AND = 6'h24, F_OR = 6'h25;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL} alu_op_e;

  logic              rst;
  logic [31:0]       imem_q [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
  logic [DATA_W-1:0] gpr_q  [32];

  // IF / IF-ID
  logic [IA_W-1:0] pc_q, pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;

  // ID
  logic [5:0]        id_op, id_funct;
  logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
  logic [DATA_W-1:0] id_rs_val, id_rt_val, id_imm;
  logic              dec_wr, dec_mrd, dec_mwr, dec_use_imm, stall;
  logic [4:0]        dec_dst;
  alu_op_e           dec_alu;

  // ID-EX
  logic [4:0]        idex_rs_q, idex_rt_q, idex_dst_q, idex_shamt_q;
  logic [DATA_W-1:0] idex_a_q, idex_b_q, idex_imm_q;
  logic              idex_wr_q, idex_mrd_q, idex_mwr_q, idex_use_imm_q;
  alu_op_e           idex_alu_q;

  // EX
  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res;

  // EX-MEM / MEM / MEM-WB
  logic [DATA_W-1:0] exmem_res_q, exmem_sd_q, mem_val, memwb_val_q;
  logic [4:0]        exmem_dst_q, memwb_dst_q;
  logic              exmem_wr_q, exmem_mrd_q, exmem_mwr_q, memwb_wr_q, st_fire;
  logic [DATA_W-1:0] peri_addr_q, peri_data_q;

  assign rst      = rst_n;
  assign id_op    = ifid_instr_q[31:26];
  assign id_rs    = ifid_instr_q[25:21];
  assign id_rt    = ifid_instr_q[20:16];
  assign id_rd    = ifid_instr_q[15:11];
  assign id_shamt = ifid_instr_q[10:6];
  assign id_funct = ifid_instr_q[5:0];
  assign id_imm   = DATA_W'($signed(ifid_instr_q[15:0]));

  // Boot port: instruction memory is only writable while the core is held
  always_ff @(posedge clk) begin
    if (!rst && boot_up && !boot_web) imem_q[boot_addr[IA_W-1:0]] <= boot_datai;
  end

  // Fetch: next PC and IF-ID contents, frozen during a load-use stall
  always_comb begin
    pc_d         = pc_q + 1'b1;
    ifid_instr_d = imem_q[pc_q];
    if (stall) begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
    end
  end

  // Decode; writes to r0 are dropped here so no later stage needs to test for it
  always_comb begin
    dec_wr      = 1'b0;
    dec_mrd     = 1'b0;
    dec_mwr     = 1'b0;
    dec_use_imm = 1'b0;
    dec_dst     = id_rt;
    dec_alu     = ALU_ADD;
    case (id_op)
      OP_RTYPE: begin
        dec_dst = id_rd;
        dec_wr  = 1'b1;
        case (id_funct)
          F_ADD:   dec_alu = ALU_ADD;
          F_SUB:   dec_alu = ALU_SUB;
          F_AND:   dec_alu = ALU_AND;
          F_OR:    dec_alu = ALU_OR;
          F_SLL:   dec_alu = ALU_SLL;
          F_SRL:   dec_alu = ALU_SRL;
          default: dec_wr  = 1'b0;
        endcase
      end
      OP_ADDI: begin dec_wr = 1'b1; dec_use_imm = 1'b1; end
      OP_LW:   begin dec_wr = 1'b1; dec_mrd = 1'b1; dec_use_imm = 1'b1; end
      OP_SW:   begin dec_mwr = 1'b1; dec_use_imm = 1'b1; end
      default: ;
    endcase
    if (dec_dst == '0) dec_wr = 1'b0;
  end

  // Register read with write-through from WB, and load-use hazard detection
  always_comb begin
    id_rs_val = gpr_q[id_rs];
    id_rt_val = gpr_q[id_rt];
    if (memwb_wr_q && memwb_dst_q == id_rs) id_rs_val = memwb_val_q;
    if (memwb_wr_q && memwb_dst_q == id_rt) id_rt_val = memwb_val_q;
    if (id_rs == '0) id_rs_val = '0;
    if (id_rt == '0) id_rt_val = '0;
    stall = idex_mrd_q && idex_wr_q && (idex_dst_q == id_rs || idex_dst_q == id_rt);
  end

  // Execute: forwarding (EX-MEM wins over MEM-WB) and the ALU.
  // A load never sits in EX-MEM while its consumer is in EX thanks to the stall.
  always_comb begin
    fwd_a = idex_a_q;
    fwd_b = idex_b_q;
    if (exmem_wr_q && exmem_dst_q == idex_rs_q)      fwd_a = exmem_res_q;
    else if (memwb_wr_q && memwb_dst_q == idex_rs_q) fwd_a = memwb_val_q;
    if (exmem_wr_q && exmem_dst_q == idex_rt_q)      fwd_b = exmem_res_q;
    else if (memwb_wr_q && memwb_dst_q == idex_rt_q) fwd_b = memwb_val_q;
    alu_b   = idex_use_imm_q ? idex_imm_q : fwd_b;
    alu_res = fwd_a + alu_b;
    case (idex_alu_q)
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      // shift counts of DATA_W or more shift every bit out, giving 0
      ALU_SLL: alu_res = fwd_b << idex_shamt_q;
      ALU_SRL: alu_res = fwd_b >> idex_shamt_q;
      default: ;
    endcase
  end

  assign mem_val = exmem_mrd_q ? dmem_q[exmem_res_q[DA_W-1:0]] : exmem_res_q;
  assign st_fire = exmem_mwr_q & ~boot_up;

  // Pipeline registers; reset and boot both flush to bubbles and park PC at 0
  always_ff @(posedge clk) begin
    if (rst || boot_up) begin
      pc_q         <= '0;
      ifid_instr_q <= '0;
      idex_wr_q    <= 1'b0;
      idex_mrd_q   <= 1'b0;
      idex_mwr_q   <= 1'b0;
      exmem_wr_q   <= 1'b0;
      exmem_mrd_q  <= 1'b0;
      exmem_mwr_q  <= 1'b0;
      memwb_wr_q   <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ifid_instr_q   <= ifid_instr_d;
      idex_wr_q      <= dec_wr && !stall;
      idex_mrd_q     <= dec_mrd && !stall;
      idex_mwr_q     <= dec_mwr && !stall;
      idex_use_imm_q <= dec_use_imm;
      idex_alu_q     <= dec_alu;
      idex_dst_q     <= dec_dst;
      idex_rs_q      <= id_rs;
      idex_rt_q      <= id_rt;
      idex_shamt_q   <= id_shamt;
      idex_a_q       <= id_rs_val;
      idex_b_q       <= id_rt_val;
      idex_imm_q     <= id_imm;
      exmem_res_q    <= alu_res;
      exmem_sd_q     <= fwd_b;
      exmem_dst_q    <= idex_dst_q;
      exmem_wr_q     <= idex_wr_q;
      exmem_mrd_q    <= idex_mrd_q;
      exmem_mwr_q    <= idex_mwr_q;
      memwb_val_q    <= mem_val;
      memwb_dst_q    <= exmem_dst_q;
      memwb_wr_q     <= exmem_wr_q;
    end
  end

  // Register file: cleared by reset, written from WB unless the core is held
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (!boot_up && memwb_wr_q) begin
      gpr_q[memwb_dst_q] <= memwb_val_q;
    end
  end

  // Data memory store in MEM
  always_ff @(posedge clk) begin
    if (!rst && st_fire) dmem_q[exmem_res_q[DA_W-1:0]] <= exmem_sd_q;
  end

  // Peripheral address/data hold the last store between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      peri_addr_q <= '0;
      peri_data_q <= '0;
    end else if (st_fire) begin
      peri_addr_q <= exmem_res_q;
      peri_data_q <= exmem_sd_q;
    end
  end

  assign peri_web   = ~st_fire;
  assign peri_addr  = st_fire ? exmem_res_q : peri_addr_q;
  assign peri_datao = st_fire ? exmem_sd_q  : peri_data_q;

endmodule

// File: tb/tb_top_pipe_cpu.sv
// Bench for top_pipe_cpu: programs are booted into imem, run, and every store
// seen on the peripheral port is compared with an instruction-level model.
module tb_top_pipe_cpu;
  typedef struct packed {logic [15:0] addr; logic [15:0] data;} st_t;

  logic        clk = 1'b0;
  logic        rst_n, boot_up, boot_web, peri_web;
  logic [7:0]  boot_addr;
  logic [31:0] boot_datai;
  logic [15:0] peri_addr, peri_datao;

  int unsigned n_checks = 0, n_errors = 0;
  logic [31:0] prog [256];
  int          plen;
  logic [15:0] m_gpr  [32];
  logic [15:0] m_dmem [256];
  st_t         exp_q[$], obs_q[$], dir_q[$];
  logic [5:0]  fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02};

  top_pipe_cpu #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .boot_up(boot_up), .boot_addr(boot_addr),
    .boot_datai(boot_datai), .boot_web(boot_web), .peri_web(peri_web),
    .peri_addr(peri_addr), .peri_datao(peri_datao)
  );

  always #5 clk = ~clk;

  // Record every store strobe seen on the peripheral port
  always @(negedge clk) begin
    if (peri_web === 1'b0) obs_q.push_back({peri_addr, peri_datao});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt,
                                        input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = '0;
    plen = 0;
  endtask

  task automatic add(input logic [31:0] w);
    prog[plen] = w;
    plen++;
  endtask

  task automatic wreg(input int idx, input int v);
    if (idx != 0) m_gpr[idx] = 16'(v);
  endtask

  // Sequential instruction-level execution of the program, one instruction at a time
  task automatic model_run();
    int op, rs, rt, rd, sh, fn, a, b, imm, ad;
    for (int p = 0; p < plen; p++) begin
      op = int'(prog[p][31:26]); rs = int'(prog[p][25:21]); rt = int'(prog[p][20:16]);
      rd = int'(prog[p][15:11]); sh = int'(prog[p][10:6]);  fn = int'(prog[p][5:0]);
      a = int'(m_gpr[rs]); b = int'(m_gpr[rt]); imm = int'(prog[p][15:0]);
      ad = (a + imm) % 65536;
      case (op)
        'h00: case (fn)
          'h20: wreg(rd, a + b);
          'h22: wreg(rd, a - b);
          'h24: wreg(rd, a & b);
          'h25: wreg(rd, a | b);
          'h00: wreg(rd, (sh >= 16) ? 0 : b << sh);
          'h02: wreg(rd, (sh >= 16) ? 0 : b >> sh);
          default: ;
        endcase
        'h08: wreg(rt, ad);
        'h23: wreg(rt, int'(m_dmem[ad % 256]));
        'h2B: begin
          m_dmem[ad % 256] = 16'(b);
          exp_q.push_back({16'(ad), 16'(b)});
        end
        default: ;
      endcase
    end
  endtask

  task automatic run_prog(input bit reload, input bit poke, input string tag);
    @(negedge clk);
    boot_up = 1'b1;
    if (reload) begin
      for (int i = 0; i < 256; i++) begin
        boot_addr = 8'(i); boot_datai = prog[i]; boot_web = 1'b0;
        @(negedge clk);
      end
    end
    boot_web = 1'b1;
    @(negedge clk);
    obs_q.delete(); exp_q.delete();
    model_run();
    boot_up = 1'b0;
    for (int c = 0; c < 230; c++) begin
      // boot writes while running must not reach imem (a rerun would expose them)
      if (poke && c >= 150 && c < 154) begin
        boot_web = 1'b0; boot_addr = 8'(c - 150); boot_datai = enc_i(6'h2B, 0, 1, 200);
      end else boot_web = 1'b1;
      @(negedge clk);
    end
    boot_web = 1'b1; boot_up = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, " store_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), obs_q[i].addr, exp_q[i].addr);
      check($sformatf("%s data[%0d]", tag, i), obs_q[i].data, exp_q[i].data);
    end
    check({tag, " web_idle"}, peri_web, 1'b1);
    if (exp_q.size() > 0) begin
      check({tag, " addr_hold"}, peri_addr, exp_q[exp_q.size()-1].addr);
      check({tag, " data_hold"}, peri_datao, exp_q[exp_q.size()-1].data);
    end
  endtask

  task automatic build_directed();
    logic [15:0] vals [17] = '{16'd0, 16'd60, 16'd70, 16'd240, 16'd35, 16'd208, 16'd32,
                               16'd208, 16'd243, 16'd240, 16'd35, 16'hFFFF, 16'd1, 16'd0,
                               16'd0, 16'hFFFD, 16'h7000};
    clear_prog();
    dir_q.delete();
    for (int i = 1; i < 32; i++) begin add(enc_i(6'h2B, 0, i, 32 + i)); dir_q.push_back({16'(32 + i), 16'd0}); end
    add(enc_i(6'h08, 0, 1, 15));      add(enc_i(6'h08, 0, 3, 20));
    add(enc_r(6'h20, 3, 1, 4, 0));    add(enc_r(6'h20, 4, 1, 5, 0));
    add(enc_i(6'h2B, 0, 5, 2));       dir_q.push_back({16'd2, 16'd50});
    add(enc_i(6'h23, 0, 6, 2));       add(enc_i(6'h08, 6, 7, 10));  add(enc_i(6'h08, 6, 8, 20));
    add(enc_r(6'h00, 0, 7, 9, 2));    add(enc_r(6'h02, 0, 8, 10, 1));
    add(enc_i(6'h2B, 0, 7, 2));       dir_q.push_back({16'd2, 16'd60});
    add(enc_i(6'h2B, 0, 8, 4));       dir_q.push_back({16'd4, 16'd70});
    add(enc_i(6'h2B, 0, 9, 6));       dir_q.push_back({16'd6, 16'd240});
    add(enc_i(6'h2B, 0, 10, 8));      dir_q.push_back({16'd8, 16'd35});
    add(enc_i(6'h23, 0, 1, 2));       add(enc_i(6'h23, 0, 2, 4));
    add(enc_i(6'h23, 0, 3, 6));       add(enc_i(6'h23, 0, 4, 8));
    add(enc_r(6'h22, 9, 10, 5, 0));   add(enc_r(6'h24, 9, 10, 6, 0));
    add(enc_r(6'h25, 9, 10, 7, 0));   add(enc_r(6'h25, 9, 10, 8, 0));
    add(enc_r(6'h22, 8, 10, 5, 0));   add(enc_r(6'h22, 8, 10, 7, 0));
    add(enc_i(6'h08, 0, 0, 5));
    add(enc_i(6'h08, 0, 12, 1));      add(enc_r(6'h22, 0, 12, 11, 0));
    add(32'hFC21_0800);               add(enc_r(6'h21, 9, 10, 1, 0));
    add(enc_r(6'h00, 0, 9, 13, 20));  add(enc_r(6'h02, 0, 9, 14, 31));
    add(enc_i(6'h08, 0, 15, -3));     add(enc_i(6'h08, 0, 16, 'h7000));
    add(enc_i(6'h2B, 16, 9, 'h105));  dir_q.push_back({16'h7105, 16'd240});
    for (int i = 0; i < 17; i++) begin add(enc_i(6'h2B, 0, i, 64 + i)); dir_q.push_back({16'(64 + i), vals[i]}); end
  endtask

  task automatic build_random();
    int k;
    logic [5:0] op, fn;
    clear_prog();
    for (int i = 0; i < 16; i++) add(enc_i(6'h2B, 0, i % 8, i));
    for (int n = 0; n < 70; n++) begin
      k = $urandom_range(0, 9);
      if (k <= 3)      add(enc_r(fn_tab[$urandom_range(0, 5)], $urandom_range(0, 7),
                                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31)));
      else if (k <= 5) add(enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
      else if (k == 6) add(enc_i(6'h23, 0, $urandom_range(0, 7), $urandom_range(0, 15)));
      else if (k == 7) add(enc_i(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
      else if (k == 8) begin
        if ($urandom_range(0, 1) == 0) begin
          do op = 6'($urandom_range(1, 63)); while (op inside {6'h08, 6'h23, 6'h2B});
          add({op, 26'($urandom)});
        end else begin
          do fn = 6'($urandom_range(0, 63)); while (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02});
          add({6'h00, 20'($urandom), fn});
        end
      end else add(32'h0);
    end
    for (int i = 1; i < 8; i++) add(enc_i(6'h2B, 0, i, 240 + i));
  endtask

  initial begin
    rst_n = 1'b1; boot_up = 1'b1; boot_web = 1'b1; boot_addr = '0; boot_datai = '0;
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset peri_web", peri_web, 1'b1);
    check("reset peri_addr", peri_addr, 16'h0);
    check("reset peri_datao", peri_datao, 16'h0);

    build_directed();
    run_prog(1'b1, 1'b1, "directed");
    check("directed table_count", obs_q.size(), dir_q.size());
    for (int i = 0; i < obs_q.size() && i < dir_q.size(); i++) begin
      check($sformatf("directed table addr[%0d]", i), obs_q[i].addr, dir_q[i].addr);
      check($sformatf("directed table data[%0d]", i), obs_q[i].data, dir_q[i].data);
    end
    run_prog(1'b0, 1'b0, "rerun");

    for (int r = 0; r < 3; r++) begin
      build_random();
      run_prog(1'b1, 1'b0, $sformatf("random%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
